// File: rtl/cache_mem_pkg.sv
// Shared encodings for the cache memory responder: request types, FSM states
// and the stall LFSR tap mask.
package cache_mem_pkg;

   localparam logic [2:0] TYPE_BYTE = 3'b000;
   localparam logic [2:0] TYPE_HALF = 3'b001;
   localparam logic [2:0] TYPE_WORD = 3'b010;
   localparam logic [2:0] TYPE_LINE = 3'b100;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_BEAT = 2'd2
   } rd_state_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_BUSY = 1'b1
   } wr_state_t;

   // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Only the line code is special; every other code moves a single word.
   function automatic logic is_line(input logic [2:0] t);
      return t == TYPE_LINE;
   endfunction

endpackage

// File: rtl/cache_mem_array.sv
// Word-addressed storage: one combinational word read port, one line-organised
// write port with per-word enables and per-word byte enables. Never reset.
module cache_mem_array #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] i_rd_idx,
   output logic [31:0]       o_rd_data,
   input  logic [ADDR_W-3:0] i_wr_line,
   input  logic [3:0]        i_wr_word_en,
   input  logic [15:0]       i_wr_be,
   input  logic [127:0]      i_wr_data
);

   logic [31:0] r_mem [0:(1<<ADDR_W)-1];

   assign o_rd_data = r_mem[i_rd_idx];

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (i_wr_word_en[k]) begin
            for (int b = 0; b < 4; b++) begin
               if (i_wr_be[4*k+b])
                  r_mem[{i_wr_line, 2'(k)}][8*b +: 8] <= i_wr_data[32*k+8*b +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache refill/writeback port with programmable
// latency. Define CACHE_MEM_RAND_STALL_EN to enable LFSR-driven random stalls.
//
// Handshakes: a request is taken on a clock edge where req & rdy are both high;
// rdy never depends combinationally on req. Return beats are not back-pressured.
module cache_mem_responder
   import cache_mem_pkg::*;
#(
   parameter int          ADDR_W    = 12,
   parameter int          RD_LAT    = 3,
   parameter int          WR_LAT    = 2,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         rd_req,
   input  logic [2:0]   rd_type,
   input  logic [31:0]  rd_addr,
   output logic         rd_rdy,
   output logic         ret_valid,
   output logic         ret_last,
   output logic [31:0]  ret_data,
   input  logic         wr_req,
   input  logic [2:0]   wr_type,
   input  logic [31:0]  wr_addr,
   input  logic [3:0]   wr_wstrb,
   input  logic [127:0] wr_data,
   output logic         wr_rdy,
   output logic [1:0]   o_dbg_rd_state,
   output logic         o_dbg_wr_state
);

   localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1) + 1;

   rd_state_t         r_rd_state, w_rd_state_n;
   logic [CNT_W-1:0]  r_rd_cnt, w_rd_cnt_n;
   logic [1:0]        r_beat, w_beat_n;
   logic [ADDR_W-1:0] r_rd_widx, w_rd_widx_n;
   logic              r_rd_line, w_rd_line_n;
   logic              r_rd_rdy, w_rd_rdy_n;
   logic              r_ret_valid, w_ret_valid_n;
   logic              r_ret_last, w_ret_last_n;
   logic [31:0]       r_ret_data, w_ret_data_n;
   logic              w_issue;

   wr_state_t         r_wr_state, w_wr_state_n;
   logic [CNT_W-1:0]  r_wr_cnt, w_wr_cnt_n;
   logic              r_wr_rdy, w_wr_rdy_n;

   logic              w_stall_n;
   logic              w_wr_acc;
   logic              w_wr_is_line;
   logic [3:0]        w_wr_word_en;
   logic [15:0]       w_wr_be;
   logic [127:0]      w_wr_data;
   logic [ADDR_W-3:0] w_wr_line;
   logic [1:0]        w_beat_idx;
   logic [ADDR_W-1:0] w_issue_base;
   logic              w_issue_line;
   logic [ADDR_W-1:0] w_rd_idx;
   logic [31:0]       w_mem_rd;
   logic [31:0]       w_fwd_word;
   logic              w_unused;

   assign w_unused = &{1'b0, rd_addr[31:ADDR_W+2], rd_addr[1:0],
                       wr_addr[31:ADDR_W+2], wr_addr[1:0], LFSR_SEED};

`ifdef CACHE_MEM_RAND_STALL_EN
   logic [15:0] r_lfsr;
   logic [15:0] w_lfsr_n;

   assign w_lfsr_n  = {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
   // Registered outputs look at the LFSR value of the cycle they will appear in.
   assign w_stall_n = w_lfsr_n[0];

   always_ff @(posedge clk) begin
      if (!resetn) r_lfsr <= LFSR_SEED;
      else         r_lfsr <= w_lfsr_n;
   end
`else
   assign w_stall_n = 1'b0;
`endif

   // Write side: commit at the acceptance edge; non-line data is replicated
   // into every word lane so the array only needs one lane select.
   assign w_wr_acc     = wr_req & r_wr_rdy & resetn;
   assign w_wr_is_line = is_line(wr_type);
   assign w_wr_word_en = !w_wr_acc    ? 4'h0 :
                         w_wr_is_line ? 4'hF : (4'b0001 << wr_addr[3:2]);
   assign w_wr_be      = w_wr_is_line ? 16'hFFFF : {4{wr_wstrb}};
   assign w_wr_data    = w_wr_is_line ? wr_data : {4{wr_data[31:0]}};
   assign w_wr_line    = wr_addr[ADDR_W+1:4];

   // Word to present next: beat index advances only after a beat was shown.
   assign w_beat_idx   = (r_rd_state != R_BEAT) ? 2'd0 :
                         r_ret_valid ? (r_beat + 2'd1) : r_beat;
   assign w_issue_base = (r_rd_state == R_IDLE) ? rd_addr[ADDR_W+1:2] : r_rd_widx;
   assign w_issue_line = (r_rd_state == R_IDLE) ? is_line(rd_type) : r_rd_line;
   assign w_rd_idx     = w_issue_line ? {w_issue_base[ADDR_W-1:2], w_beat_idx} : w_issue_base;

   cache_mem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk          (clk),
      .i_rd_idx     (w_rd_idx),
      .o_rd_data    (w_mem_rd),
      .i_wr_line    (w_wr_line),
      .i_wr_word_en (w_wr_word_en),
      .i_wr_be      (w_wr_be),
      .i_wr_data    (w_wr_data)
   );

   // A write committing on the same edge wins, so the beat sees it.
   always_comb begin
      w_fwd_word = w_mem_rd;
      if (w_wr_line == w_rd_idx[ADDR_W-1:2] && w_wr_word_en[w_rd_idx[1:0]]) begin
         for (int b = 0; b < 4; b++) begin
            if (w_wr_be[4*int'(w_rd_idx[1:0])+b])
               w_fwd_word[8*b +: 8] = w_wr_data[32*int'(w_rd_idx[1:0])+8*b +: 8];
         end
      end
   end

   always_comb begin
      w_rd_state_n  = r_rd_state;
      w_rd_cnt_n    = r_rd_cnt;
      w_beat_n      = r_beat;
      w_rd_widx_n   = r_rd_widx;
      w_rd_line_n   = r_rd_line;
      w_rd_rdy_n    = 1'b0;
      w_ret_valid_n = 1'b0;
      w_ret_last_n  = 1'b0;
      w_ret_data_n  = '0;
      w_issue       = 1'b0;
      case (r_rd_state)
         R_IDLE: begin
            w_rd_rdy_n = ~w_stall_n;
            if (rd_req && r_rd_rdy) begin
               w_rd_widx_n = rd_addr[ADDR_W+1:2];
               w_rd_line_n = is_line(rd_type);
               w_rd_rdy_n  = 1'b0;
               if (RD_LAT == 0) begin
                  w_rd_state_n = R_BEAT;
                  w_issue      = 1'b1;
               end else begin
                  w_rd_state_n = R_WAIT;
                  w_rd_cnt_n   = CNT_W'(RD_LAT);
               end
            end
         end
         R_WAIT: begin
            w_rd_cnt_n = r_rd_cnt - CNT_W'(1);
            if (r_rd_cnt == CNT_W'(1)) begin
               w_rd_state_n = R_BEAT;
               w_issue      = 1'b1;
            end
         end
         R_BEAT: begin
            if (r_ret_valid && r_ret_last) begin
               w_rd_state_n = R_IDLE;
               w_rd_rdy_n   = ~w_stall_n;
            end else begin
               w_issue = 1'b1;
            end
         end
         default: w_rd_state_n = R_IDLE;
      endcase
      // A stalled beat keeps its index and is offered again next cycle.
      if (w_issue) begin
         w_beat_n = w_beat_idx;
         if (!w_stall_n) begin
            w_ret_valid_n = 1'b1;
            w_ret_data_n  = w_fwd_word;
            w_ret_last_n  = ~w_issue_line | (w_beat_idx == 2'd3);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rd_state  <= R_IDLE;
         r_rd_cnt    <= '0;
         r_beat      <= '0;
         r_rd_widx   <= '0;
         r_rd_line   <= 1'b0;
         r_rd_rdy    <= 1'b1;
         r_ret_valid <= 1'b0;
         r_ret_last  <= 1'b0;
         r_ret_data  <= '0;
      end else begin
         r_rd_state  <= w_rd_state_n;
         r_rd_cnt    <= w_rd_cnt_n;
         r_beat      <= w_beat_n;
         r_rd_widx   <= w_rd_widx_n;
         r_rd_line   <= w_rd_line_n;
         r_rd_rdy    <= w_rd_rdy_n;
         r_ret_valid <= w_ret_valid_n;
         r_ret_last  <= w_ret_last_n;
         r_ret_data  <= w_ret_data_n;
      end
   end

   always_comb begin
      w_wr_state_n = r_wr_state;
      w_wr_cnt_n   = r_wr_cnt;
      w_wr_rdy_n   = 1'b0;
      case (r_wr_state)
         W_IDLE: begin
            w_wr_rdy_n = ~w_stall_n;
            if (w_wr_acc && (WR_LAT != 0)) begin
               w_wr_state_n = W_BUSY;
               w_wr_cnt_n   = CNT_W'(WR_LAT);
               w_wr_rdy_n   = 1'b0;
            end
         end
         W_BUSY: begin
            w_wr_cnt_n = r_wr_cnt - CNT_W'(1);
            if (r_wr_cnt == CNT_W'(1)) begin
               w_wr_state_n = W_IDLE;
               w_wr_rdy_n   = ~w_stall_n;
            end
         end
         default: w_wr_state_n = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_state <= W_IDLE;
         r_wr_cnt   <= '0;
         r_wr_rdy   <= 1'b1;
      end else begin
         r_wr_state <= w_wr_state_n;
         r_wr_cnt   <= w_wr_cnt_n;
         r_wr_rdy   <= w_wr_rdy_n;
      end
   end

   assign rd_rdy         = r_rd_rdy;
   assign ret_valid      = r_ret_valid;
   assign ret_last       = r_ret_last;
   assign ret_data       = r_ret_data;
   assign wr_rdy         = r_wr_rdy;
   assign o_dbg_rd_state = r_rd_state;
   assign o_dbg_wr_state = r_wr_state;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: directed scenarios plus random
// traffic checked every cycle against a timeline/array reference model.
module tb_cache_mem_responder;

   localparam int ADDR_W = 12;
   localparam int RD_LAT = 3;
   localparam int WR_LAT = 2;
   localparam int NWORDS = 1 << ADDR_W;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         rd_req = 1'b0;
   logic [2:0]   rd_type = 3'b000;
   logic [31:0]  rd_addr = '0;
   logic         rd_rdy;
   logic         ret_valid;
   logic         ret_last;
   logic [31:0]  ret_data;
   logic         wr_req = 1'b0;
   logic [2:0]   wr_type = 3'b000;
   logic [31:0]  wr_addr = '0;
   logic [3:0]   wr_wstrb = 4'h0;
   logic [127:0] wr_data = '0;
   logic         wr_rdy;
   logic [1:0]   dbg_rd_state;
   logic         dbg_wr_state;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   cache_mem_responder #(
      .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk            (clk),
      .resetn         (resetn),
      .rd_req         (rd_req),
      .rd_type        (rd_type),
      .rd_addr        (rd_addr),
      .rd_rdy         (rd_rdy),
      .ret_valid      (ret_valid),
      .ret_last       (ret_last),
      .ret_data       (ret_data),
      .wr_req         (wr_req),
      .wr_type        (wr_type),
      .wr_addr        (wr_addr),
      .wr_wstrb       (wr_wstrb),
      .wr_data        (wr_data),
      .wr_rdy         (wr_rdy),
      .o_dbg_rd_state (dbg_rd_state),
      .o_dbg_wr_state (dbg_wr_state)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Memory image plus a timeline: each accepted read schedules its beats at
   // absolute edge numbers; ready flags come from "busy until edge" markers.
   typedef struct {
      int edge_n;
      int word;
      bit last;
   } beat_t;

   logic [31:0] mm [0:NWORDS-1];
   bit          known [0:NWORDS-1];
   beat_t       exp_q[$];
   int          cyc = 0;
   int          rd_free = 0;
   int          wr_free = 0;
   bit          e_rd_rdy = 1'b1;
   bit          e_wr_rdy = 1'b1;
   bit          e_valid = 1'b0;
   bit          e_last = 1'b0;
   bit          e_known = 1'b0;
   logic [31:0] e_data = '0;

   task automatic model_write();
      int w;
      w = int'(wr_addr[ADDR_W+1:2]);
      if (wr_type == 3'b100) begin
         for (int k = 0; k < 4; k++) begin
            mm[(w & ~3) + k]    = wr_data[32*k +: 32];
            known[(w & ~3) + k] = 1'b1;
         end
      end else begin
         for (int b = 0; b < 4; b++)
            if (wr_wstrb[b]) mm[w][8*b +: 8] = wr_data[8*b +: 8];
         if (wr_wstrb == 4'hF) known[w] = 1'b1;
      end
   endtask

   task automatic model_read_accept();
      int    w;
      int    nb;
      beat_t b;
      w  = int'(rd_addr[ADDR_W+1:2]);
      nb = (rd_type == 3'b100) ? 4 : 1;
      for (int k = 0; k < nb; k++) begin
         b.edge_n = cyc + RD_LAT + k;
         b.word   = (nb == 4) ? ((w & ~3) + k) : w;
         b.last   = (k == nb - 1);
         exp_q.push_back(b);
      end
      rd_free = cyc + RD_LAT + nb;
   endtask

   // One clock: advance the model with the inputs the DUT saw, then compare.
   task automatic tick();
      beat_t b;
      bit    in_reset;
      @(posedge clk);
      cyc++;
      in_reset = !resetn;
      if (in_reset) begin
         exp_q.delete();
         rd_free  = cyc;
         wr_free  = cyc;
         e_rd_rdy = 1'b1;
         e_wr_rdy = 1'b1;
         e_valid  = 1'b0;
         e_last   = 1'b0;
         e_known  = 1'b0;
      end else begin
         if (wr_req && e_wr_rdy) begin
            model_write();
            wr_free = cyc + WR_LAT;
         end
         if (rd_req && e_rd_rdy) model_read_accept();
         e_rd_rdy = (cyc >= rd_free);
         e_wr_rdy = (cyc >= wr_free);
         e_valid  = 1'b0;
         e_last   = 1'b0;
         e_known  = 1'b0;
         if (exp_q.size() != 0 && exp_q[0].edge_n == cyc) begin
            b       = exp_q.pop_front();
            e_valid = 1'b1;
            e_last  = b.last;
            e_data  = mm[b.word];
            e_known = known[b.word];
         end
      end
      #1;
      check("rd_rdy", rd_rdy, e_rd_rdy);
      check("wr_rdy", wr_rdy, e_wr_rdy);
      check("ret_valid", ret_valid, e_valid);
      check("ret_last", ret_last, e_last);
      if (e_valid && e_known) check("ret_data", ret_data, e_data);
      if (in_reset) check("rst_ret_data", ret_data, 32'h0);
   endtask

   // ---------------- driver tasks ----------------
   int          rd_acc_cyc = 0;
   logic [31:0] cap_q[$];
   bit          last_q[$];
   int          off_q[$];

   task automatic do_write(input logic [2:0] t, input logic [31:0] a,
                           input logic [3:0] s, input logic [127:0] d);
      bit acc;
      acc = 1'b0;
      wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
      for (int i = 0; i < 64 && !acc; i++) begin
         acc = e_wr_rdy;
         tick();
      end
      wr_req = 1'b0;
      if (!acc) check("wr_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_read(input logic [2:0] t, input logic [31:0] a);
      bit acc;
      acc = 1'b0;
      rd_req = 1'b1; rd_type = t; rd_addr = a;
      for (int i = 0; i < 64 && !acc; i++) begin
         acc = e_rd_rdy;
         tick();
      end
      rd_req = 1'b0;
      rd_acc_cyc = cyc;
      if (!acc) check("rd_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic collect(input int want);
      int got;
      got = 0;
      cap_q.delete(); last_q.delete(); off_q.delete();
      for (int i = 0; i < 40 && got < want; i++) begin
         tick();
         if (ret_valid === 1'b1) begin
            cap_q.push_back(ret_data);
            last_q.push_back(ret_last);
            off_q.push_back(cyc - rd_acc_cyc);
            got++;
         end
      end
      check("beat_count", got, want);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] line_exp [4];
   int          nvalid;

   initial begin
      // Reset state.
      resetn = 1'b0;
      tick();
      tick();
      check("rst_dbg_rd_idle", dbg_rd_state, 2'd0);
      resetn = 1'b1;
      tick();
      check("rel_rd_rdy", rd_rdy, 1'b1);
      check("rel_wr_rdy", wr_rdy, 1'b1);
      check("rel_ret_valid", ret_valid, 1'b0);

      // Line write then offset line read: four beats starting at word 0.
      do_write(3'b100, 32'h0000_1230, 4'h0,
               128'h44444444_33333333_22222222_11111111);
      tick();
      do_read(3'b100, 32'h0000_1234);
      check("line_rd_rdy_low", rd_rdy, 1'b0);
      collect(4);
      line_exp[0] = 32'h11111111; line_exp[1] = 32'h22222222;
      line_exp[2] = 32'h33333333; line_exp[3] = 32'h44444444;
      for (int k = 0; k < cap_q.size(); k++) begin
         check("line_beat_data", cap_q[k], line_exp[k]);
         check("line_beat_last", last_q[k], (k == 3));
         check("line_beat_time", off_q[k], RD_LAT + k);
      end
      check("rdy_on_last_beat", rd_rdy, 1'b0);
      tick();
      check("rdy_after_last", rd_rdy, 1'b1);

      // Partial word write; wr_rdy low for exactly WR_LAT cycles.
      do_write(3'b010, 32'h0000_1238, 4'b0101, {96'h0, 32'hAABBCCDD});
      check("wr_busy_0", wr_rdy, 1'b0);
      tick();
      check("wr_busy_1", wr_rdy, 1'b0);
      tick();
      check("wr_free", wr_rdy, 1'b1);
      do_read(3'b010, 32'h0000_1238);
      collect(1);
      if (cap_q.size() == 1) begin
         check("strb_word_data", cap_q[0], 32'h33BB33DD);
         check("strb_word_last", last_q[0], 1'b1);
      end

      // Address wrap beyond the memory size.
      do_write(3'b010, 32'h0000_4000, 4'hF, {96'h0, 32'h12345678});
      tick();
      do_read(3'b000, 32'h0000_0000);
      collect(1);
      if (cap_q.size() == 1) check("wrap_data", cap_q[0], 32'h12345678);

      // Same-cycle read and write: the read sees the new word.
      while (!(e_rd_rdy && e_wr_rdy)) tick();
      rd_req = 1'b1; rd_type = 3'b010; rd_addr = 32'h0000_0100;
      wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h0000_0100;
      wr_wstrb = 4'hF; wr_data = {96'h0, 32'hDEADBEEF};
      tick();
      rd_acc_cyc = cyc;
      rd_req = 1'b0; wr_req = 1'b0;
      collect(1);
      if (cap_q.size() == 1) check("same_cycle_data", cap_q[0], 32'hDEADBEEF);

      // Reset in the middle of a line read, then re-read preserved data.
      do_read(3'b100, 32'h0000_1230);
      nvalid = 0;
      for (int i = 0; i < 20 && nvalid < 2; i++) begin
         tick();
         if (ret_valid === 1'b1) nvalid++;
      end
      check("mid_read_beats", nvalid, 2);
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ret_valid === 1'b1) nvalid++;
      end
      check("valid_after_reset", nvalid, 0);
      check("rdy_after_reset", rd_rdy, 1'b1);
      do_read(3'b100, 32'h0000_1230);
      collect(4);
      line_exp[2] = 32'h33BB33DD;
      for (int k = 0; k < cap_q.size(); k++)
         check("reread_data", cap_q[k], line_exp[k]);

      // Fill words 0..127 so random reads have known contents.
      for (int l = 0; l < 32; l++)
         do_write(3'b100, l * 16, 4'h0,
                  {$urandom(), $urandom(), $urandom(), $urandom()});

      // Random overlapping traffic, every cycle checked by the model.
      for (int i = 0; i < 900; i++) begin
         rd_req   = ($urandom_range(0, 2) == 0);
         rd_type  = 3'($urandom_range(0, 7));
         rd_addr  = ($urandom() & 32'hFFFF_C003) | (32'($urandom_range(0, 127)) << 2);
         wr_req   = ($urandom_range(0, 2) == 0);
         wr_type  = 3'($urandom_range(0, 7));
         wr_addr  = ($urandom() & 32'hFFFF_C003) | (32'($urandom_range(0, 127)) << 2);
         wr_wstrb = 4'($urandom_range(0, 15));
         wr_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
      for (int i = 0; i < 12; i++) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
